// File: rtl/prefix_add_seq.sv
// prefix_add_seq
//   Multi-cycle wide adder controller. One CHUNK-bit prefix-adder slice
//   (per-bit generate/propagate cells feeding a Kogge-Stone carry tree) is
//   reused once per cycle across a WIDTH-bit operand pair. The LSB chunk is
//   processed first, and the carry between chunks is held in a register.
//
// Parameters
//   WIDTH  operand/result width, must be a multiple of CHUNK
//   CHUNK  bits processed per cycle (NCHUNK = WIDTH/CHUNK >= 1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands a, b, cin valid
//   in_ready   high while idle; an operand pair can be accepted
//   a, b       WIDTH-bit operands
//   cin        carry in
//   sub        (PREFIX_SEQ_SUB_EN only) subtract: sum = a - b, cin ignored
//   out_valid  sum/cout valid, held until out_ready
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result
//   cout       carry out of the MSB (with sub: 1 means no borrow)
//   busy       high while an operation is running or waiting to be taken
//
// Configuration macro
//   PREFIX_SEQ_SUB_EN  adds the sub input and subtract support.

module prefix_add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PREFIX_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LEVELS = (CHUNK > 1) ? $clog2(CHUNK) : 0;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] bit_g;
  logic [CHUNK-1:0] bit_p;
  logic [CHUNK-1:0] carries;
  logic [CHUNK-1:0] slice_sum;
  logic             chunk_cout;

  // Effective second operand and carry-in at accept time. Subtraction is
  // folded in here so the datapath below only ever adds.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef PREFIX_SEQ_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign slice_a = op_a[idx*CHUNK +: CHUNK];
  assign slice_b = op_b[idx*CHUNK +: CHUNK];
  assign bit_g   = slice_a & slice_b;
  assign bit_p   = slice_a ^ slice_b;

  // Kogge-Stone tree: after the last level, (gk, pk)[i] is the group
  // generate/propagate of bits i..0 of the slice.
  logic [CHUNK-1:0] gk [LEVELS+1];
  logic [CHUNK-1:0] pk [LEVELS+1];

  assign gk[0] = bit_g;
  assign pk[0] = bit_p;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int DIST = 1 << l;
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      if (i >= DIST) begin : g_merge
        assign gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-DIST]);
        assign pk[l+1][i] = pk[l][i] & pk[l][i-DIST];
      end else begin : g_pass
        assign gk[l+1][i] = gk[l][i];
        assign pk[l+1][i] = pk[l][i];
      end
    end
  end

  // Carry into bit i comes from the group below it, seeded by the carry
  // register; bit 0 takes the carry register directly.
  assign carries[0] = carry;
  for (genvar i = 1; i < CHUNK; i++) begin : g_carry
    assign carries[i] = gk[LEVELS][i-1] | (pk[LEVELS][i-1] & carry);
  end

  assign slice_sum  = bit_p ^ carries;
  assign chunk_cout = gk[LEVELS][CHUNK-1] | (pk[LEVELS][CHUNK-1] & carry);

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Controller: accept in IDLE, walk the chunks LSB first in RUN, then hold
  // the result in DONE until the consumer takes it. sum is written chunk by
  // chunk, so partial results are visible while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= slice_sum;
          carry                   <= chunk_cout;
          if (idx == LAST_IDX) begin
            cout  <= chunk_cout;
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
